booth_product_accumulator: RTL and testbench

Downstream consumer of the 4x4 Booth multiplier stage. It accepts a stream of signed 8-bit products over a valid/ready handshake and sums a fixed number of them (a dot-product term group) into a wider signed accumulator, with saturation. It presents the final sum with a one-cycle valid pulse. Its control FSM is IDLE -> ACCUM -> DONE.

---
 rtl/booth_pkg.sv | 21 ++
 rtl/booth_product_accumulator_if.sv | 31 +++
 rtl/sat_add_signed.sv | 34 +++
 rtl/booth_product_accumulator.sv | 100 ++++++++++
 tb/tb_booth_product_accumulator.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types and saturation limits for the Booth multiplier datapath and its
// downstream accumulate stages.
package booth_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    localparam int unsigned PROD_W = 8;
    localparam int unsigned ACC_W  = 12;

    // Largest (is_max=1) or smallest (is_max=0) value of an aw-bit signed number.
    function automatic int sat_limit(input int unsigned aw, input logic is_max);
        int lim;
        lim = 1 << (aw - 1);
        return is_max ? (lim - 1) : -lim;
    endfunction

endpackage

// File: rtl/booth_product_accumulator_if.sv
// Product stream in, group result out: the handshake bundle between the Booth
// multiplier stage (master) and the product accumulator (slave).
interface booth_product_accumulator_if
    import booth_pkg::*;
#(
    parameter int unsigned PW = PROD_W,
    parameter int unsigned AW = ACC_W
);

    logic                 start;
    logic                 clear;
    logic signed [PW-1:0] prod;
    logic                 prod_valid;
    logic                 prod_ready;
    logic signed [AW-1:0] acc_out;
    logic                 acc_valid;
    logic                 busy;
    logic                 ovf;
    logic [3:0]           term_cnt;

    modport master (
        output start, clear, prod, prod_valid,
        input  prod_ready, acc_out, acc_valid, busy, ovf, term_cnt
    );

    modport slave (
        input  start, clear, prod, prod_valid,
        output prod_ready, acc_out, acc_valid, busy, ovf, term_cnt
    );

endinterface

// File: rtl/sat_add_signed.sv
// Combinational signed a + sext(b) with clamping to the AW-bit range; o_ovf flags
// that the clamp was applied.
module sat_add_signed
    import booth_pkg::*;
#(
    parameter int unsigned AW = ACC_W,
    parameter int unsigned BW = PROD_W
) (
    input  logic signed [AW-1:0] i_a,
    input  logic signed [BW-1:0] i_b,
    output logic signed [AW-1:0] o_sum,
    output logic                 o_ovf
);

    logic signed [AW:0] w_sum;
    logic signed [31:0] w_sum32;

    // One guard bit is enough: two in-range operands cannot overflow AW+1 bits.
    assign w_sum   = {i_a[AW-1], i_a} + {{(AW + 1 - BW){i_b[BW-1]}}, i_b};
    assign w_sum32 = 32'(w_sum);

    always_comb begin
        o_sum = w_sum[AW-1:0];
        o_ovf = 1'b0;
        if (w_sum32 > sat_limit(AW, 1'b1)) begin
            o_sum = AW'(sat_limit(AW, 1'b1));
            o_ovf = 1'b1;
        end else if (w_sum32 < sat_limit(AW, 1'b0)) begin
            o_sum = AW'(sat_limit(AW, 1'b0));
            o_ovf = 1'b1;
        end
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums N_TERMS signed products per group into a saturating accumulator and
// pulses acc_valid for one cycle when the group sum is final.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int unsigned PW      = PROD_W,
    parameter int unsigned AW      = ACC_W,
    parameter int unsigned N_TERMS = 4
) (
    input logic i_clk,
    input logic i_n_rst,
    booth_product_accumulator_if.slave bus
);

    localparam logic [3:0] CntLast = 4'(N_TERMS - 1);

    state_e               r_state;
    state_e               w_state_d;
    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_acc_d;
    logic                 r_ovf;
    logic                 w_ovf_d;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_d;
    logic signed [AW-1:0] w_sat_sum;
    logic                 w_sat_ovf;

    sat_add_signed #(
        .AW (AW),
        .BW (PW)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (bus.prod),
        .o_sum (w_sat_sum),
        .o_ovf (w_sat_ovf)
    );

    always_comb begin
        w_state_d = r_state;
        w_acc_d   = r_acc;
        w_ovf_d   = r_ovf;
        w_cnt_d   = r_cnt;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_d = StAccum;
                    w_acc_d   = '0;
                    w_ovf_d   = 1'b0;
                    w_cnt_d   = '0;
                end
            end
            StAccum: begin
                // prod_ready is 1 throughout this state, so prod_valid alone is a transfer.
                if (bus.prod_valid) begin
                    w_acc_d = w_sat_sum;
                    w_ovf_d = r_ovf | w_sat_ovf;
                    w_cnt_d = r_cnt + 4'd1;
                    if (r_cnt == CntLast) begin
                        w_state_d = StDone;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
        // Abort outranks start and any transfer in the same cycle.
        if (bus.clear) begin
            w_state_d = StIdle;
            w_acc_d   = '0;
            w_ovf_d   = 1'b0;
            w_cnt_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_n_rst) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_acc   <= w_acc_d;
            r_ovf   <= w_ovf_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign bus.prod_ready = (r_state == StAccum);
    assign bus.busy       = (r_state != StIdle);
    assign bus.acc_valid  = (r_state == StDone);
    assign bus.acc_out    = r_acc;
    assign bus.ovf        = r_ovf;
    assign bus.term_cnt   = r_cnt;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Drives identical stimulus into a 12-bit and an 8-bit accumulator and checks both
// every cycle against a group-level reference model.
module tb_booth_product_accumulator;

    localparam int N = 4;

    logic              clk;
    logic              n_rst;
    logic              start;
    logic              clear;
    logic signed [7:0] prod;
    logic              prod_valid;

    int n_checks = 0;
    int n_fail   = 0;

    booth_product_accumulator_if #(.PW(8), .AW(12)) if12 ();
    booth_product_accumulator_if #(.PW(8), .AW(8))  if8 ();

    assign if12.start      = start;
    assign if12.clear      = clear;
    assign if12.prod       = prod;
    assign if12.prod_valid = prod_valid;
    assign if8.start       = start;
    assign if8.clear       = clear;
    assign if8.prod        = prod;
    assign if8.prod_valid  = prod_valid;

    booth_product_accumulator #(.PW(8), .AW(12), .N_TERMS(N)) u_dut12 (
        .i_clk   (clk),
        .i_n_rst (n_rst),
        .bus     (if12.slave)
    );

    booth_product_accumulator #(.PW(8), .AW(8), .N_TERMS(N)) u_dut8 (
        .i_clk   (clk),
        .i_n_rst (n_rst),
        .bus     (if8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: group-level behaviour in plain integers.
    bit m_live   = 0;
    bit m_in_acc = 0;
    bit m_done   = 0;
    int m_cnt    = 0;
    int m_acc12  = 0;
    int m_acc8   = 0;
    bit m_ovf12  = 0;
    bit m_ovf8   = 0;

    function automatic int clamp(input int s, input int aw);
        int hi;
        int lo;
        hi = (1 << (aw - 1)) - 1;
        lo = -(1 << (aw - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    always @(posedge clk) begin
        int s;
        if (!n_rst) begin
            m_live = 1; m_in_acc = 0; m_done = 0; m_cnt = 0;
            m_acc12 = 0; m_acc8 = 0; m_ovf12 = 0; m_ovf8 = 0;
        end else if (clear) begin
            m_in_acc = 0; m_done = 0; m_cnt = 0;
            m_acc12 = 0; m_acc8 = 0; m_ovf12 = 0; m_ovf8 = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_in_acc) begin
            if (start) begin
                m_in_acc = 1; m_cnt = 0;
                m_acc12 = 0; m_acc8 = 0; m_ovf12 = 0; m_ovf8 = 0;
            end
        end else if (prod_valid) begin
            s = m_acc12 + int'(prod);
            if (clamp(s, 12) != s) m_ovf12 = 1;
            m_acc12 = clamp(s, 12);
            s = m_acc8 + int'(prod);
            if (clamp(s, 8) != s) m_ovf8 = 1;
            m_acc8 = clamp(s, 8);
            m_cnt++;
            if (m_cnt == N) begin
                m_in_acc = 0;
                m_done   = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("acc_out12",    if12.acc_out,    m_acc12);
            check("ovf12",        if12.ovf,        m_ovf12);
            check("acc_out8",     if8.acc_out,     m_acc8);
            check("ovf8",         if8.ovf,         m_ovf8);
            check("acc_valid12",  if12.acc_valid,  m_done);
            check("acc_valid8",   if8.acc_valid,   m_done);
            check("prod_ready12", if12.prod_ready, m_in_acc);
            check("prod_ready8",  if8.prod_ready,  m_in_acc);
            check("busy12",       if12.busy,       m_in_acc | m_done);
            check("busy8",        if8.busy,        m_in_acc | m_done);
            check("term_cnt12",   if12.term_cnt,   m_cnt);
            check("term_cnt8",    if8.term_cnt,    m_cnt);
        end
    end

    // All drive tasks are entered and left 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic signed [7:0] v, input int stall);
        repeat (stall) begin
            prod_valid = 1'b0;
            prod       = 8'($urandom);
            tick();
        end
        prod_valid = 1'b1;
        prod       = v;
        tick();
        prod_valid = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; clear = 1'b0; prod = '0; prod_valid = 1'b0;
        tick();
        n_rst = 1'b1;
        check("rst_acc_out", if12.acc_out, 0);
        check("rst_ready",   if12.prod_ready, 0);
        tick();

        // Basic group 15, -8, 21, 6 = 34.
        do_start();
        send(8'sd15, 0); send(-8'sd8, 0); send(8'sd21, 0); send(8'sd6, 0);
        check("basic_valid", if12.acc_valid, 1);
        check("basic_acc",   if12.acc_out, 34);
        check("basic_cnt",   if12.term_cnt, 4);
        check("basic_ovf",   if12.ovf, 0);
        check("model_basic", m_acc12, 34);
        tick();

        // Same group with two-cycle stalls between terms.
        do_start();
        send(8'sd15, 2); send(-8'sd8, 2); send(8'sd21, 2); send(8'sd6, 2);
        check("stall_valid", if12.acc_valid, 1);
        check("stall_acc",   if12.acc_out, 34);
        tick();

        // Positive clamp at 8 bits: 127, 77, 87.
        do_start();
        send(8'sd100, 0); send(8'sd100, 0);
        check("sat_first_acc", if8.acc_out, 127);
        check("sat_first_ovf", if8.ovf, 1);
        send(-8'sd50, 0);
        check("sat_second_acc", if8.acc_out, 77);
        send(8'sd10, 0);
        check("sat_final_acc", if8.acc_out, 87);
        check("sat_final_ovf", if8.ovf, 1);
        check("sat_wide_acc",  if12.acc_out, 160);
        check("sat_wide_ovf",  if12.ovf, 0);
        check("model_sat",     m_acc8, 87);
        tick();

        // Negative clamp at 8 bits.
        do_start();
        send(-8'sd100, 0); send(-8'sd100, 0); send(8'sd0, 0); send(8'sd0, 0);
        check("neg_acc",      if8.acc_out, -128);
        check("neg_ovf",      if8.ovf, 1);
        check("neg_wide_acc", if12.acc_out, -200);
        tick();

        // Clear mid-group drops the concurrent product.
        do_start();
        send(8'sd9, 0); send(8'sd9, 0);
        prod_valid = 1'b1; prod = 8'sd9; clear = 1'b1;
        tick();
        clear = 1'b0; prod_valid = 1'b0;
        check("clr_acc",   if12.acc_out, 0);
        check("clr_cnt",   if12.term_cnt, 0);
        check("clr_busy",  if12.busy, 0);
        check("clr_valid", if12.acc_valid, 0);
        do_start();
        send(8'sd1, 0); send(8'sd1, 0); send(8'sd1, 0); send(8'sd1, 0);
        check("after_clr_acc", if12.acc_out, 4);
        tick();

        // Reset mid-group.
        do_start();
        send(8'sd5, 0);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check("mrst_acc",   if12.acc_out, 0);
        check("mrst_ready", if12.prod_ready, 0);
        check("mrst_cnt",   if12.term_cnt, 0);
        check("mrst_busy",  if12.busy, 0);
        repeat (3) tick();
        check("mrst_ready_hold", if12.prod_ready, 0);

        // Randomised traffic, checked every cycle by the model.
        repeat (800) begin
            start      = ($urandom % 4) == 0;
            clear      = ($urandom % 40) == 0;
            prod_valid = ($urandom % 4) != 0;
            prod       = 8'($urandom);
            n_rst      = ($urandom % 300) != 0;
            tick();
        end
        n_rst = 1'b1; start = 1'b0; clear = 1'b0; prod_valid = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
